pipe_hazard_unit: RTL and testbench

- Parametrised hazard-detection and forwarding block for the in-order pipeline (IF/ID -> ID/EX -> EX/MEM -> MEM/WB).
- Replaces software-inserted NOPs between dependent instructions.
- Keeps a shadow pipeline of in-flight destination registers, stalls IF/ID on unresolvable hazards, and selects the forwarded operands that are latched into ID/EX.
- Supports a forwarding mode and a stall-only mode, and counts stall cycles.

---
 rtl/pipe_hazard_unit.sv | 128 ++++++++++++
 tb/tb_pipe_hazard_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand forwarding for the in-order pipeline.
// A shadow pipeline tracks the destination of every in-flight instruction
// after ID; operands are either forwarded from the youngest producer or the
// ID stage is stalled until the producer's result becomes usable.
module pipe_hazard_unit #(
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 16,
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_src_addr,
    input  logic                     id_src_used,
    input  logic [REG_ADDR_W-1:0]    id_dst_addr,
    input  logic                     id_dst_read,
    input  logic                     id_wb,
    input  logic                     id_mr,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        rf_src_data,
    input  logic [DATA_W-1:0]        rf_dst_data,
    input  logic [STAGES*DATA_W-1:0] stage_data,
    output logic [DATA_W-1:0]        src_data,
    output logic [DATA_W-1:0]        dst_data,
    output logic [3:0]               src_sel,
    output logic [3:0]               dst_sel,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_count
);

    // Shadow entry k: index 0 = EX, 1 = MEM, 2 = WB, ...
    logic [STAGES-1:0]                 v_q, v_d;
    logic [STAGES-1:0]                 wb_q, wb_d;
    logic [STAGES-1:0]                 mr_q, mr_d;
    logic [STAGES-1:0][REG_ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]                  stall_count_q, stall_count_d;

    logic src_haz, dst_haz;

    // Youngest producer wins. A load younger than LOAD_STAGE has no usable
    // result yet, and in stall-only mode every producer is a hazard.
    function automatic void lookup(
        input  logic [REG_ADDR_W-1:0] addr,
        input  logic [DATA_W-1:0]     rf,
        output logic                  haz,
        output logic [3:0]            sel,
        output logic [DATA_W-1:0]     data
    );
        logic found;
        haz   = 1'b0;
        sel   = 4'd0;
        data  = rf;
        found = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (!found && v_q[k] && wb_q[k] && dst_q[k] == addr) begin
                found = 1'b1;
                if (FWD_EN == 0 || (mr_q[k] && k < LOAD_STAGE)) begin
                    haz = 1'b1;
                end else begin
                    sel  = 4'(k + 1);
                    data = stage_data[k*DATA_W +: DATA_W];
                end
            end
        end
    endfunction

    // Operand selection and stall decision, zero latency from ID inputs.
    always_comb begin
        src_haz = 1'b0;
        dst_haz = 1'b0;
        src_sel = 4'd0;
        dst_sel = 4'd0;
        src_data = rf_src_data;
        dst_data = rf_dst_data;
        lookup(id_src_addr, rf_src_data, src_haz, src_sel, src_data);
        lookup(id_dst_addr, rf_dst_data, dst_haz, dst_sel, dst_data);
        // flush kills the ID instruction, so it can never stall
        stall = id_valid & ~flush &
                ((id_src_used & src_haz) | (id_dst_read & dst_haz));
    end

    // Shadow pipeline advance; a stalled or flushed ID inserts a bubble and
    // flush also kills the instruction moving from EX to MEM.
    always_comb begin
        v_d   = v_q;
        wb_d  = wb_q;
        mr_d  = mr_q;
        dst_d = dst_q;
        v_d[0]   = id_valid & ~stall & ~flush;
        dst_d[0] = id_dst_addr;
        wb_d[0]  = id_wb;
        mr_d[0]  = id_mr;
        for (int k = 1; k < STAGES; k++) begin
            v_d[k]   = v_q[k-1] & ~(flush && k == 1);
            dst_d[k] = dst_q[k-1];
            wb_d[k]  = wb_q[k-1];
            mr_d[k]  = mr_q[k-1];
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && stall_count_q != {CNT_W{1'b1}}) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State registers; reset only needs to clear valid bits and the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q           <= '0;
            stall_count_q <= '0;
        end else begin
            v_q           <= v_d;
            wb_q          <= wb_d;
            mr_q          <= mr_d;
            dst_q         <= dst_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench: two instances (forwarding, and stall-only with a 2-bit
// counter) share one stimulus stream; a reference model predicts each
// cycle's response and a monitor compares on the falling edge.
module tb_pipe_hazard_unit;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int ST = 3;
    localparam int LS = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [AW-1:0]   id_src_addr = '0;
    logic            id_src_used = 1'b0;
    logic [AW-1:0]   id_dst_addr = '0;
    logic            id_dst_read = 1'b0;
    logic            id_wb = 1'b0;
    logic            id_mr = 1'b0;
    logic            flush = 1'b0;
    logic [DW-1:0]   rf_src_data = '0;
    logic [DW-1:0]   rf_dst_data = '0;
    logic [ST*DW-1:0] stage_data = '0;

    logic [DW-1:0] src_data1, dst_data1, src_data0, dst_data0;
    logic [3:0]    src_sel1, dst_sel1, src_sel0, dst_sel0;
    logic          stall1, stall0;
    logic [15:0]   cnt1;
    logic [1:0]    cnt0;

    pipe_hazard_unit #(.REG_ADDR_W(AW), .DATA_W(DW), .STAGES(ST), .LOAD_STAGE(LS),
                       .FWD_EN(1), .CNT_W(16)) dut_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_read(id_dst_read),
        .id_wb(id_wb), .id_mr(id_mr), .flush(flush), .rf_src_data(rf_src_data),
        .rf_dst_data(rf_dst_data), .stage_data(stage_data), .src_data(src_data1),
        .dst_data(dst_data1), .src_sel(src_sel1), .dst_sel(dst_sel1), .stall(stall1),
        .stall_count(cnt1));

    pipe_hazard_unit #(.REG_ADDR_W(AW), .DATA_W(DW), .STAGES(ST), .LOAD_STAGE(LS),
                       .FWD_EN(0), .CNT_W(2)) dut_stl (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_read(id_dst_read),
        .id_wb(id_wb), .id_mr(id_mr), .flush(flush), .rf_src_data(rf_src_data),
        .rf_dst_data(rf_dst_data), .stage_data(stage_data), .src_data(src_data0),
        .dst_data(dst_data0), .src_sel(src_sel0), .dst_sel(dst_sel0), .stall(stall0),
        .stall_count(cnt0));

    // Model of in-flight instructions, ordered by age (0 = just left ID).
    typedef struct packed {
        bit       v;
        bit [2:0] dst;
        bit       wb;
        bit       mr;
    } ent_t;

    typedef struct {
        bit        s1;
        bit [3:0]  ss1, ds1;
        bit [15:0] sd1, dd1;
        int        c1;
        bit        s0;
        bit [15:0] rs, rd;
        int        c0;
    } exp_t;

    ent_t hm[2][ST];   // [0] = stall-only model, [1] = forwarding model
    int   cm[2];
    int   cmax[2] = '{3, 65535};
    bit   sm[2];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Find the newest in-flight writer of a register and decide forward/stall.
    function automatic void resolve(input int m, input bit [2:0] a, input bit [15:0] rf,
                                    output bit haz, output bit [3:0] sel, output bit [15:0] d);
        haz = 0;
        sel = 0;
        d   = rf;
        for (int age = 0; age < ST; age++) begin
            if (hm[m][age].v && hm[m][age].wb && hm[m][age].dst == a) begin
                if (m == 0 || (hm[m][age].mr && age < LS)) haz = 1;
                else begin
                    sel = 4'(age + 1);
                    d   = stage_data[age*DW +: DW];
                end
                return;
            end
        end
    endfunction

    // Retire the oldest, admit the ID instruction (if it was not held/killed).
    function automatic void advance();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int a = 0; a < ST; a++) hm[m][a].v = 0;
                cm[m] = 0;
            end else begin
                if (flush) hm[m][0].v = 0;
                for (int a = ST - 1; a > 0; a--) hm[m][a] = hm[m][a-1];
                hm[m][0].v   = id_valid && !sm[m] && !flush;
                hm[m][0].dst = id_dst_addr;
                hm[m][0].wb  = id_wb;
                hm[m][0].mr  = id_mr;
                if (sm[m] && cm[m] < cmax[m]) cm[m]++;
            end
        end
    endfunction

    function automatic void predict();
        exp_t e;
        bit hs, hd;
        bit [3:0] ss, ds;
        bit [15:0] sd, dd;
        for (int m = 0; m < 2; m++) begin
            resolve(m, id_src_addr, rf_src_data, hs, ss, sd);
            resolve(m, id_dst_addr, rf_dst_data, hd, ds, dd);
            sm[m] = id_valid && !flush && ((id_src_used && hs) || (id_dst_read && hd));
            if (m == 1) begin
                e.ss1 = ss; e.ds1 = ds; e.sd1 = sd; e.dd1 = dd;
            end
        end
        e.s1 = sm[1];
        e.c1 = cm[1];
        e.s0 = sm[0];
        e.c0 = cm[0];
        e.rs = rf_src_data;
        e.rd = rf_dst_data;
        sb.push_back(e);
    endfunction

    task automatic issue(input bit v, input bit [2:0] s, input bit su, input bit [2:0] d,
                         input bit dr, input bit wb, input bit mr, input bit fl, input bit r);
        @(posedge clk);
        advance();
        #1;
        rst = r; id_valid = v; id_src_addr = s; id_src_used = su;
        id_dst_addr = d; id_dst_read = dr; id_wb = wb; id_mr = mr; flush = fl;
        rf_src_data = 16'($urandom);
        rf_dst_data = 16'($urandom);
        for (int k = 0; k < ST; k++) stage_data[k*DW +: DW] = 16'($urandom);
        predict();
    endtask

    // Re-present the held ID instruction while either instance stalls.
    task automatic hold();
        int n = 0;
        while ((sm[0] || sm[1]) && n < 8) begin
            issue(id_valid, id_src_addr, id_src_used, id_dst_addr, id_dst_read,
                  id_wb, id_mr, 1'b0, 1'b0);
            n++;
        end
        if (n >= 8) begin
            errors++;
            $display("FAIL hold_bound: stall did not clear within %0d cycles", n);
        end
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        repeat (2) issue(1, 3, 1, 3, 1, 1, 0, 0, 1);
    endtask

    // Monitor: every cycle the DUTs present a response; pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("fwd_stall", 32'(stall1), 32'(e.s1));
            chk("fwd_count", 32'(cnt1), e.c1);
            if (!e.s1) begin
                chk("fwd_src_sel", 32'(src_sel1), 32'(e.ss1));
                chk("fwd_dst_sel", 32'(dst_sel1), 32'(e.ds1));
                chk("fwd_src_data", 32'(src_data1), 32'(e.sd1));
                chk("fwd_dst_data", 32'(dst_data1), 32'(e.dd1));
            end
            chk("stl_stall", 32'(stall0), 32'(e.s0));
            chk("stl_count", 32'(cnt0), e.c0);
            if (!e.s0) begin
                chk("stl_src_sel", 32'(src_sel0), 0);
                chk("stl_dst_sel", 32'(dst_sel0), 0);
                chk("stl_src_data", 32'(src_data0), 32'(e.rs));
                chk("stl_dst_data", 32'(dst_data0), 32'(e.rd));
            end
        end
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < ST; a++) hm[m][a] = '0;
            cm[m] = 0;
            sm[m] = 0;
        end

        // 1: reset with a valid instruction presented
        do_reset();
        @(negedge clk);
        chk("rst_stall", 32'(stall1), 0);
        chk("rst_src_sel", 32'(src_sel1), 0);
        chk("rst_count", 32'(cnt1), 0);
        issue(1, 3, 1, 3, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_sel", 32'(src_sel1), 0);
        hold();

        // 2: EX forward
        do_reset();
        issue(1, 0, 0, 7, 0, 1, 0, 0, 0);
        issue(1, 7, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("exfwd_stall", 32'(stall1), 0);
        chk("exfwd_sel", 32'(src_sel1), 1);
        chk("exfwd_data", 32'(src_data1), 32'(stage_data[DW-1:0]));
        hold();

        // 3: load-use, one stall then forward from MEM
        do_reset();
        issue(1, 0, 0, 5, 0, 1, 1, 0, 0);
        issue(1, 5, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_stall", 32'(stall1), 1);
        issue(1, 5, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_stall2", 32'(stall1), 0);
        chk("lu_sel", 32'(src_sel1), 2);
        chk("lu_data", 32'(src_data1), 32'(stage_data[DW +: DW]));
        chk("lu_count", 32'(cnt1), 1);
        hold();

        // 4: youngest producer wins
        do_reset();
        issue(1, 0, 0, 2, 0, 1, 0, 0, 0);
        nop();
        issue(1, 0, 0, 2, 0, 1, 0, 0, 0);
        issue(1, 2, 1, 4, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("young_sel", 32'(src_sel1), 1);
        chk("young_data", 32'(src_data1), 32'(stage_data[DW-1:0]));
        hold();

        // 5: stall-only instance: back-to-back dependency stalls 3 cycles
        do_reset();
        issue(1, 0, 0, 7, 0, 1, 0, 0, 0);
        issue(1, 7, 1, 1, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            chk("stl_run", 32'(stall0), 1);
            issue(1, 7, 1, 1, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        chk("stl_run3", 32'(stall0), 1);
        issue(1, 7, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stl_done", 32'(stall0), 0);
        chk("stl_sel", 32'(src_sel0), 0);
        chk("stl_count3", 32'(cnt0), 3);
        // another 3-cycle stall must saturate the 2-bit counter at 3
        issue(1, 0, 0, 6, 0, 1, 0, 0, 0);
        issue(1, 6, 1, 1, 0, 0, 0, 0, 0);
        hold();
        @(negedge clk);
        chk("stl_sat", 32'(cnt0), 3);

        // 6: flush beats a load-use stall and kills the load
        do_reset();
        issue(1, 0, 0, 5, 0, 1, 1, 0, 0);
        issue(1, 5, 1, 1, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("fl_stall", 32'(stall1), 0);
        issue(1, 5, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("fl_next_stall", 32'(stall1), 0);
        chk("fl_next_sel", 32'(src_sel1), 0);
        chk("fl_count", 32'(cnt1), 0);
        hold();

        // random traffic; stalled instructions are usually held in ID
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ((sm[0] || sm[1]) && $urandom_range(3) != 0)
                issue(id_valid, id_src_addr, id_src_used, id_dst_addr, id_dst_read,
                      id_wb, id_mr, 1'($urandom_range(7) == 0), 1'($urandom_range(99) == 0));
            else
                issue(1'($urandom_range(3) != 0), 3'($urandom_range(7)), 1'($urandom_range(1)),
                      3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(3) != 0),
                      1'($urandom_range(2) == 0), 1'($urandom_range(7) == 0),
                      1'($urandom_range(99) == 0));
        end
        nop();
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
